// File: rtl/stage6wb_pkg.sv
// Instruction-set header for the write-back stage: field positions, opcodes, classification.
// Pure declarations, no logic or latency of its own.
// Not applicable to flow control; consumed by the stage and its register file.
package stage6wb_pkg;

   localparam int DATA_W  = 24;
   localparam int REG_AW  = 4;
   localparam int FLAG_W  = 4;

   // Opcode lives in the top nibble of the instruction word; rd is in [15:12].
   localparam int OPC_MSB = 23;
   localparam int OPC_LSB = 20;

   localparam logic [3:0] OPC_NOP  = 4'h0;
   localparam logic [3:0] OPC_ADD  = 4'h1;
   localparam logic [3:0] OPC_ADDI = 4'h2;
   localparam logic [3:0] OPC_SUB  = 4'h3;
   localparam logic [3:0] OPC_CMP  = 4'h4;
   localparam logic [3:0] OPC_MOV  = 4'h5;
   localparam logic [3:0] OPC_ST   = 4'h6;
   localparam logic [3:0] OPC_HLT  = 4'hF;

   localparam logic [DATA_W-1:0] NOP_WORD = 24'h000000;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   function automatic logic [3:0] opcode_of(input logic [DATA_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

   // ALU results and moves land in rd; compares, stores, NOP and HLT do not.
   function automatic logic writes_rd(input logic [DATA_W-1:0] instr);
      logic r;
      r = 1'b0;
      if (instr != NOP_WORD) begin
         case (opcode_of(instr))
            OPC_ADD, OPC_ADDI, OPC_SUB, OPC_MOV: r = 1'b1;
            default:                             r = 1'b0;
         endcase
      end
      return r;
   endfunction

   // Arithmetic and compare update flags; moves, stores, NOP and HLT leave them alone.
   function automatic logic sets_flags(input logic [DATA_W-1:0] instr);
      logic r;
      r = 1'b0;
      if (instr != NOP_WORD) begin
         case (opcode_of(instr))
            OPC_ADD, OPC_ADDI, OPC_SUB, OPC_CMP: r = 1'b1;
            default:                             r = 1'b0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/stage6wb_regfile_2r1w.sv
// Architectural register array: two combinational read ports, one synchronous write port.
// Read latency 0 (no bypass here), write visible one cycle after the edge.
// No backpressure; the write is taken whenever we is high.
module regfile_2r1w
   import stage6wb_pkg::*;
#(
   parameter int REG_COUNT = 16,
   parameter int R0_ZERO   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs_q [REG_COUNT];
   logic [DATA_W-1:0] regs_d [REG_COUNT];

   // Next-state of the array: one entry updated, R0 writes dropped when hardwired.
   always_comb begin
      regs_d = regs_q;
      if (we && (int'(waddr) < REG_COUNT) && !((R0_ZERO != 0) && (waddr == '0))) begin
         regs_d[waddr] = wdata;
      end
   end

   // Array state with synchronous clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Combinational reads; out-of-range and hardwired-R0 addresses return 0.
   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if ((int'(raddr_a) < REG_COUNT) && !((R0_ZERO != 0) && (raddr_a == '0))) rdata_a = regs_q[raddr_a];
      if ((int'(raddr_b) < REG_COUNT) && !((R0_ZERO != 0) && (raddr_b == '0))) rdata_b = regs_q[raddr_b];
   end

endmodule

// File: rtl/stage6wb.sv
// Write-back stage: retires instructions into regfile, flags, retire counter and last PC.
// Updates land one cycle after the retiring edge; reads see same-cycle writes via bypass.
// No backpressure; enable_in is taken every cycle in RUN and ignored once HALTED.
module stage6wb
   import stage6wb_pkg::*;
#(
   parameter int REG_COUNT = 16,
   parameter int R0_ZERO   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_in,
   input  logic [23:0] pc_in,
   input  logic [23:0] instr_in,
   input  logic [23:0] result_in,
   input  logic [3:0]  flags_in,
   input  logic [3:0]  reg_waddr_in,
   input  logic [3:0]  raddr_a,
   input  logic [3:0]  raddr_b,
   output logic [23:0] rdata_a,
   output logic [23:0] rdata_b,
   output logic [3:0]  flags_out,
   output logic [23:0] retired_out,
   output logic [23:0] last_pc_out,
   output logic        halted_out
);

   state_t            state_q,   state_d;
   logic [FLAG_W-1:0] flags_q,   flags_d;
   logic [DATA_W-1:0] retired_q, retired_d;
   logic [DATA_W-1:0] last_pc_q, last_pc_d;

   logic              retire;
   logic              wr_en;
   logic [DATA_W-1:0] rf_rdata_a;
   logic [DATA_W-1:0] rf_rdata_b;

   // Reset in the same cycle discards the instruction, so it also gates the bypass.
   assign retire = rst && enable_in && (state_q == ST_RUN);
   assign wr_en  = retire && writes_rd(instr_in);

   regfile_2r1w #(
      .REG_COUNT (REG_COUNT),
      .R0_ZERO   (R0_ZERO)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_en),
      .waddr   (reg_waddr_in),
      .wdata   (result_in),
      .raddr_a (raddr_a),
      .raddr_b (raddr_b),
      .rdata_a (rf_rdata_a),
      .rdata_b (rf_rdata_b)
   );

   // Next state for FSM, flags, retire counter and last PC.
   always_comb begin
      state_d   = state_q;
      flags_d   = flags_q;
      retired_d = retired_q;
      last_pc_d = last_pc_q;
      if (retire) begin
         retired_d = retired_q + 24'd1;
         last_pc_d = pc_in;
         if (sets_flags(instr_in))           flags_d = flags_in;
         if (opcode_of(instr_in) == OPC_HLT) state_d = ST_HALTED;
      end
   end

   // Stage state with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         flags_q   <= '0;
         retired_q <= '0;
         last_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         retired_q <= retired_d;
         last_pc_q <= last_pc_d;
      end
   end

   // Write-through bypass; a hardwired R0 stays 0 even when bypassed.
   always_comb begin
      rdata_a = rf_rdata_a;
      rdata_b = rf_rdata_b;
      if (wr_en && (raddr_a == reg_waddr_in)) rdata_a = result_in;
      if (wr_en && (raddr_b == reg_waddr_in)) rdata_b = result_in;
      if ((R0_ZERO != 0) && (raddr_a == '0))  rdata_a = '0;
      if ((R0_ZERO != 0) && (raddr_b == '0))  rdata_b = '0;
   end

   assign flags_out   = flags_q;
   assign retired_out = retired_q;
   assign last_pc_out = last_pc_q;
   assign halted_out  = (state_q == ST_HALTED);

endmodule

// File: tb/tb_stage6wb.sv
// Directed bench for stage6wb: one instance with a writable R0, one with R0 hardwired to zero.
// Inputs change on the falling edge; bypass checked before the rising edge, state after it.
// Expected values are hand-computed constants.
module tb_stage6wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable_in;
   logic [23:0] pc_in, instr_in, result_in;
   logic [3:0]  flags_in, reg_waddr_in, raddr_a, raddr_b;

   logic [23:0] rdata_a, rdata_b, retired_out, last_pc_out;
   logic [3:0]  flags_out;
   logic        halted_out;

   logic [23:0] z_rdata_a, z_rdata_b, z_retired_out, z_last_pc_out;
   logic [3:0]  z_flags_out;
   logic        z_halted_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Instruction words: opcode in [23:20], rd in [15:12].
   localparam logic [23:0] I_ADDI_R5 = 24'h205000;
   localparam logic [23:0] I_MOV_R7  = 24'h507000;
   localparam logic [23:0] I_MOV_R3  = 24'h503000;
   localparam logic [23:0] I_CMP     = 24'h400000;
   localparam logic [23:0] I_MOV_R0  = 24'h500000;
   localparam logic [23:0] I_NOP     = 24'h000000;
   localparam logic [23:0] I_HLT     = 24'hF00000;

   stage6wb #(.REG_COUNT(16), .R0_ZERO(0)) dut (
      .clk(clk), .rst(rst), .enable_in(enable_in), .pc_in(pc_in), .instr_in(instr_in),
      .result_in(result_in), .flags_in(flags_in), .reg_waddr_in(reg_waddr_in),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
      .flags_out(flags_out), .retired_out(retired_out), .last_pc_out(last_pc_out),
      .halted_out(halted_out)
   );

   stage6wb #(.REG_COUNT(16), .R0_ZERO(1)) dut_z (
      .clk(clk), .rst(rst), .enable_in(enable_in), .pc_in(pc_in), .instr_in(instr_in),
      .result_in(result_in), .flags_in(flags_in), .reg_waddr_in(reg_waddr_in),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(z_rdata_a), .rdata_b(z_rdata_b),
      .flags_out(z_flags_out), .retired_out(z_retired_out), .last_pc_out(z_last_pc_out),
      .halted_out(z_halted_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [23:0] pc, input logic [23:0] instr,
                        input logic [23:0] res, input logic [3:0] flg, input logic [3:0] wa);
      enable_in    = en;
      pc_in        = pc;
      instr_in     = instr;
      result_in    = res;
      flags_in     = flg;
      reg_waddr_in = wa;
   endtask

   task automatic edge_and_settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      raddr_a = 4'd5;
      raddr_b = 4'd0;
      // Reset held with a valid write presented: reset wins, instruction discarded.
      drive(1'b1, 24'h000008, I_ADDI_R5, 24'h000777, 4'b1111, 4'd5);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 24'h0, I_NOP, 24'h0, 4'h0, 4'd0);
      #1;
      check("rst_retired", retired_out, 24'h0);
      check("rst_last_pc", last_pc_out, 24'h0);
      check("rst_flags",   {20'h0, flags_out}, 24'h0);
      check("rst_halted",  {23'h0, halted_out}, 24'h0);
      check("rst_r5",      rdata_a, 24'h0);

      // ADDI r5 = 0x123, sets flags 1010.
      @(negedge clk);
      drive(1'b1, 24'h000010, I_ADDI_R5, 24'h000123, 4'b1010, 4'd5);
      edge_and_settle();
      enable_in = 1'b0;
      check("addi_r5",      rdata_a, 24'h000123);
      check("addi_retired", retired_out, 24'h000001);
      check("addi_last_pc", last_pc_out, 24'h000010);
      check("addi_flags",   {20'h0, flags_out}, 24'h00000A);

      // MOV r7 = 0xABCDEF: bypass on port b in the write cycle; flags untouched.
      @(negedge clk);
      raddr_b = 4'd7;
      drive(1'b1, 24'h000014, I_MOV_R7, 24'hABCDEF, 4'b0101, 4'd7);
      #1;
      check("bypass_b_r7", rdata_b, 24'hABCDEF);
      edge_and_settle();
      enable_in = 1'b0;
      check("mov_r7_reg",     rdata_b, 24'hABCDEF);
      check("mov_flags_held", {20'h0, flags_out}, 24'h00000A);
      check("mov_retired",    retired_out, 24'h000002);

      // MOV r3 = 0x333 with both ports reading r3: identical data.
      @(negedge clk);
      raddr_a = 4'd3;
      raddr_b = 4'd3;
      drive(1'b1, 24'h000018, I_MOV_R3, 24'h000333, 4'b0000, 4'd3);
      #1;
      check("bypass_a_r3", rdata_a, 24'h000333);
      check("bypass_b_r3", rdata_b, 24'h000333);
      edge_and_settle();
      enable_in = 1'b0;
      check("r3_reg", rdata_a, 24'h000333);

      // enable low: no bypass, no state change.
      @(negedge clk);
      raddr_a = 4'd5;
      drive(1'b0, 24'h00001C, I_ADDI_R5, 24'h000999, 4'b1111, 4'd5);
      #1;
      check("idle_no_bypass", rdata_a, 24'h000123);
      edge_and_settle();
      check("idle_r5",      rdata_a, 24'h000123);
      check("idle_retired", retired_out, 24'h000003);
      check("idle_flags",   {20'h0, flags_out}, 24'h00000A);

      // CMP sets flags 0011 but writes no register.
      @(negedge clk);
      drive(1'b1, 24'h000020, I_CMP, 24'h000777, 4'b0011, 4'd5);
      #1;
      check("cmp_no_bypass", rdata_a, 24'h000123);
      edge_and_settle();
      enable_in = 1'b0;
      check("cmp_flags", {20'h0, flags_out}, 24'h000003);
      check("cmp_r5",    rdata_a, 24'h000123);

      // MOV r0 = 9: writable R0 takes it, hardwired R0 reads 0 throughout.
      @(negedge clk);
      raddr_a = 4'd0;
      drive(1'b1, 24'h000024, I_MOV_R0, 24'h000009, 4'b0000, 4'd0);
      #1;
      check("r0_bypass",      rdata_a,   24'h000009);
      check("r0z_bypass",     z_rdata_a, 24'h000000);
      edge_and_settle();
      enable_in = 1'b0;
      check("r0_after",       rdata_a,   24'h000009);
      check("r0z_after",      z_rdata_a, 24'h000000);
      check("r0_retired",     retired_out, 24'h000005);
      check("r0z_retired",    z_retired_out, 24'h000005);

      // Counter wrap: preload FFFFFF, then retire a NOP.
      @(negedge clk);
      force dut.retired_q = 24'hFFFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.retired_q;
      drive(1'b1, 24'h000030, I_NOP, 24'h000555, 4'b1100, 4'd5);
      raddr_a = 4'd5;
      #1;
      check("wrap_pre",     retired_out, 24'hFFFFFF);
      check("nop_no_bypass", rdata_a, 24'h000123);
      edge_and_settle();
      enable_in = 1'b0;
      check("wrap_retired", retired_out, 24'h000000);
      check("nop_last_pc",  last_pc_out, 24'h000030);
      check("nop_flags",    {20'h0, flags_out}, 24'h000003);
      check("nop_r5",       rdata_a, 24'h000123);

      // HLT at 0x40 retires and halts from the next cycle.
      @(negedge clk);
      drive(1'b1, 24'h000040, I_HLT, 24'h000000, 4'b1111, 4'd0);
      #1;
      check("hlt_pre_halted", {23'h0, halted_out}, 24'h0);
      edge_and_settle();
      enable_in = 1'b0;
      check("hlt_halted",  {23'h0, halted_out}, 24'h1);
      check("hlt_last_pc", last_pc_out, 24'h000040);
      check("hlt_retired", retired_out, 24'h000001);
      check("hlt_flags",   {20'h0, flags_out}, 24'h000003);

      // Halted: a write to r3 is ignored, including the bypass.
      @(negedge clk);
      raddr_b = 4'd3;
      drive(1'b1, 24'h000044, I_MOV_R3, 24'h000055, 4'b1001, 4'd3);
      #1;
      check("halt_no_bypass", rdata_b, 24'h000333);
      edge_and_settle();
      enable_in = 1'b0;
      check("halt_r3",      rdata_b, 24'h000333);
      check("halt_retired", retired_out, 24'h000001);
      check("halt_last_pc", last_pc_out, 24'h000040);
      check("halt_flags",   {20'h0, flags_out}, 24'h000003);
      check("halt_stays",   {23'h0, halted_out}, 24'h1);

      // Reset leaves HALTED and clears everything.
      @(negedge clk);
      rst = 1'b0;
      edge_and_settle();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst2_halted",  {23'h0, halted_out}, 24'h0);
      check("rst2_retired", retired_out, 24'h0);
      check("rst2_last_pc", last_pc_out, 24'h0);
      check("rst2_r3",      rdata_b, 24'h0);

      // Runs again after reset.
      @(negedge clk);
      drive(1'b1, 24'h000050, I_MOV_R3, 24'h000042, 4'b0000, 4'd3);
      edge_and_settle();
      enable_in = 1'b0;
      check("rerun_r3",      rdata_b, 24'h000042);
      check("rerun_retired", retired_out, 24'h000001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
